// File: rtl/acc16_pkg.sv
// Shared constants, loader state encoding and instruction field slices for the acc16 core.
// The CKSUM state exists only when ACC16_LOADER_CKSUM_EN is defined.
package acc16_pkg;

  localparam int L_INS = 401;
  localparam int L_TOT = 1024;

  localparam logic [15:0] MAGIC = 16'hA16C;
  localparam logic [15:0] END_W = 16'hA16D;

  localparam int IND      = 15;
  localparam int OP_MSB   = 14;
  localparam int OP_LSB   = 10;
  localparam int ADDR_MSB = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_LEN,
    ST_PAYLOAD,
    ST_DONE,
    ST_ERR
`ifdef ACC16_LOADER_CKSUM_EN
    , ST_CKSUM
`endif
  } loader_state_t;

  // Depth of the selected region, wide enough to compare against base+N without wrapping.
  function automatic logic [10:0] region_depth(input logic sel);
    return sel ? 11'(L_TOT - L_INS) : 11'(L_INS);
  endfunction

endpackage

// File: rtl/acc16_cksum16.sv
// Running 16-bit wrap-around sum of payload words with an equality compare against a trailing word.
module acc16_cksum16 (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        acc_en,
  input  logic [15:0] acc_data,
  input  logic [15:0] cmp_data,
  output logic        match
);

  logic [15:0] sum_q;

  always_ff @(posedge clk1) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + acc_data;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/acc16_prog_loader.sv
// Stream loader for the acc16 instruction/data memories; holds the core until the boot word arrives.
// Define ACC16_LOADER_CKSUM_EN to require a trailing checksum word after each segment payload.
module acc16_prog_loader
  import acc16_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        err,
  output logic [7:0]  seg_cnt
);

  loader_state_t state_q, next_state;

  logic        sel_q;
  logic [9:0]  base_q;
  logic [9:0]  addr_q;
  logic [9:0]  rem_q;

  logic        accept;
  logic        last_word;
  logic        range_bad;
  logic        seg_done;
  logic [10:0] end_addr;

  assign accept    = in_valid && in_ready;
  assign last_word = (rem_q == 10'd1);
  assign end_addr  = {1'b0, base_q} + {1'b0, in_data[ADDR_MSB:0]};
  assign range_bad = (in_data[ADDR_MSB:0] == '0) || (end_addr > region_depth(sel_q));

`ifdef ACC16_LOADER_CKSUM_EN
  logic cksum_ok;

  acc16_cksum16 u_cksum (
    .clk1     (clk1),
    .rst      (rst),
    .clear    (accept && state_q == ST_HDR_LEN),
    .acc_en   (accept && state_q == ST_PAYLOAD),
    .acc_data (in_data),
    .cmp_data (in_data),
    .match    (cksum_ok)
  );

  assign seg_done = accept && (state_q == ST_CKSUM) && cksum_ok;
`else
  assign seg_done = accept && (state_q == ST_PAYLOAD) && last_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves next_state unassigned (no latch).
    next_state = state_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == MAGIC)               next_state = ST_HDR_ADDR;
          else if (in_data == END_W && !err)  next_state = ST_DONE;
        end
        ST_HDR_ADDR: next_state = (in_data[OP_MSB:OP_LSB] != '0) ? ST_ERR : ST_HDR_LEN;
        ST_HDR_LEN:  next_state = range_bad ? ST_ERR : ST_PAYLOAD;
        ST_PAYLOAD: begin
`ifdef ACC16_LOADER_CKSUM_EN
          if (last_word) next_state = ST_CKSUM;
`else
          if (last_word) next_state = ST_IDLE;
`endif
        end
`ifdef ACC16_LOADER_CKSUM_EN
        ST_CKSUM:    next_state = cksum_ok ? ST_IDLE : ST_ERR;
`endif
        ST_ERR: begin
          if (in_data == MAGIC) next_state = ST_HDR_ADDR;
        end
        default: next_state = state_q;
      endcase
    end
  end

  // Reset is gated in so the link sees not-ready during the reset cycle itself.
  always_comb begin
    in_ready = rst && (state_q != ST_DONE);
  end

  // NOTE: every register here is reset; there is no storage array, so nothing is left unreset.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      sel_q     <= 1'b0;
      base_q    <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      err       <= 1'b0;
      seg_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_HDR_ADDR: begin
            sel_q  <= in_data[IND];
            base_q <= in_data[ADDR_MSB:0];
          end
          ST_HDR_LEN: begin
            addr_q <= base_q;
            rem_q  <= in_data[ADDR_MSB:0];
          end
          ST_PAYLOAD: begin
            mem_we    <= 1'b1;
            mem_sel   <= sel_q;
            mem_addr  <= addr_q;
            mem_wdata <= in_data;
            addr_q    <= addr_q + 10'd1;
            rem_q     <= rem_q - 10'd1;
          end
          default: ;
        endcase
      end
      if (next_state == ST_ERR) err <= 1'b1;
      if (seg_done && seg_cnt != 8'hFF) seg_cnt <= seg_cnt + 8'd1;
      if (state_q == ST_IDLE && next_state == ST_DONE) cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc16_prog_loader.sv
// Self-checking bench for acc16_prog_loader: randomized word streams scored against a stream-parsing model.
module tb_acc16_prog_loader;

  localparam logic [15:0] MAGIC      = 16'hA16C;
  localparam logic [15:0] END_W      = 16'hA16D;
  localparam int          INS_DEPTH  = 401;
  localparam int          DATA_DEPTH = 623;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        err;
  logic [7:0]  seg_cnt;

  always #5 clk1 = ~clk1;

  acc16_prog_loader dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .err       (err),
    .seg_cnt   (seg_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [26:0] obs_q[$];
  logic [26:0] exp_q[$];
  logic [15:0] stream_q[$];

  bit m_err, m_hold, m_done;
  int m_seg;

  always @(negedge clk1) begin
    if (mem_we === 1'b1) obs_q.push_back({mem_sel, mem_addr, mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: walk the word stream segment by segment, recording the writes it must cause.
  task automatic model_run();
    int i, base, depth, n;
    logic [15:0] w, hdr, len, d, sum;
    logic sel;
    i = 0;
    while (i < stream_q.size() && !m_done) begin
      w = stream_q[i]; i++;
      if (w == MAGIC) begin
        hdr = stream_q[i]; i++;
        if (hdr[14:10] != 5'd0) begin m_err = 1; continue; end
        len = stream_q[i]; i++;
        sel   = hdr[15];
        base  = int'(hdr[9:0]);
        n     = int'(len[9:0]);
        depth = sel ? DATA_DEPTH : INS_DEPTH;
        if (n == 0 || base + n > depth) begin m_err = 1; continue; end
        sum = '0;
        for (int k = 0; k < n; k++) begin
          d = stream_q[i]; i++;
          exp_q.push_back({sel, 10'(base + k), d});
          sum = sum + d;
        end
`ifdef ACC16_LOADER_CKSUM_EN
        d = stream_q[i]; i++;
        if (d == sum) m_seg = (m_seg < 255) ? m_seg + 1 : 255;
        else m_err = 1;
`else
        m_seg = (m_seg < 255) ? m_seg + 1 : 255;
`endif
      end else if (w == END_W && !m_err) begin
        m_hold = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic make_segment(input logic sel, input int base, input int len, input bit bad_ck);
    logic [15:0] sum, d;
    sum = '0;
    stream_q.push_back(MAGIC);
    stream_q.push_back({sel, 5'd0, 10'(base)});
    stream_q.push_back(16'(len));
    for (int k = 0; k < len; k++) begin
      d = 16'($urandom);
      sum = sum + d;
      stream_q.push_back(d);
    end
`ifdef ACC16_LOADER_CKSUM_EN
    stream_q.push_back(bad_ck ? sum + 16'd1 : sum);
`else
    if (bad_ck) sum = '0;
`endif
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    int waited;
    repeat (gap) @(negedge clk1);
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = w;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk1);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_word_timeout: in_ready=%b required 1 for word %h", in_ready, w);
      in_valid = 1'b0;
    end else begin
      @(posedge clk1);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_stream(input int max_gap);
    foreach (stream_q[i]) send_word(stream_q[i], int'($urandom_range(0, max_gap)));
    stream_q.delete();
    repeat (3) @(negedge clk1);
  endtask

  function automatic int write_diffs();
    int d;
    d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b1;
    obs_q.delete(); exp_q.delete(); stream_q.delete();
    m_err = 0; m_seg = 0; m_hold = 1; m_done = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = MAGIC;
    repeat (2) begin
      @(posedge clk1); #1;
      checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
      checks++; if (mem_we !== 1'b0)   begin failures++; $display("FAIL reset_we: got %b expected 0", mem_we); end
      checks++; if (err !== 1'b0)      begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (seg_cnt !== 8'd0)  begin failures++; $display("FAIL reset_seg: got %0d expected 0", seg_cnt); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    end
    in_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_basic_boot();
    logic [15:0] pay [3];
    pay = '{16'h1111, 16'h2222, 16'h3333};
    do_reset();
    stream_q = '{MAGIC, 16'h0005, 16'h0003, 16'h1111, 16'h2222, 16'h3333};
`ifdef ACC16_LOADER_CKSUM_EN
    stream_q.push_back(16'h6666);
`endif
    model_run();
    foreach (stream_q[i]) begin
      send_word(stream_q[i], 0);
      if (i == 2) begin
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL basic_hdr_nowrite: mem_we=%b expected 0", mem_we); end
      end
      if (i >= 3 && i <= 5) begin
        checks++;
        if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'(i + 2), pay[i-3]}) begin
          failures++;
          $display("FAIL basic_latency%0d: we=%b sel=%b addr=%0d data=%h expected we=1 sel=0 addr=%0d data=%h",
                   i - 3, mem_we, mem_sel, mem_addr, mem_wdata, i + 2, pay[i-3]);
        end
      end
    end
    stream_q.delete();
    repeat (3) @(negedge clk1);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL basic_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (seg_cnt !== 8'(m_seg)) begin failures++; $display("FAIL basic_seg: got %0d expected %0d", seg_cnt, m_seg); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b expected 0", err); end
    stream_q = '{END_W};
    model_run();
    send_word(END_W, 0);
    stream_q.delete();
    checks++; if (cpu_hold !== 1'(m_hold)) begin failures++; $display("FAIL boot_hold: got %b expected %b", cpu_hold, m_hold); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL boot_ready: got %b expected 0", in_ready); end
    repeat (4) @(negedge clk1);
    checks++; if ({in_ready, cpu_hold} !== 2'b00) begin failures++; $display("FAIL done_sticky: ready,hold=%b expected 00", {in_ready, cpu_hold}); end
  endtask

  task automatic test_data_region();
    do_reset();
    make_segment(1'b1, 256, 16, 1'b0);
    model_run();
    drive_stream(3);
    checks++; if (obs_q.size() !== 16) begin failures++; $display("FAIL data_count: got %0d writes expected 16", obs_q.size()); end
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL data_writes: %0d differences, expected 0", write_diffs()); end
    checks++; if (seg_cnt !== 8'd1) begin failures++; $display("FAIL data_seg: got %0d expected 1", seg_cnt); end
  endtask

  task automatic test_boundaries();
    do_reset();
    make_segment(1'b0, 399, 2, 1'b0);
    make_segment(1'b1, 620, 3, 1'b0);
    model_run();
    drive_stream(1);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL bound_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bound_err: got %b expected 0", err); end
    checks++; if (seg_cnt !== 8'd2) begin failures++; $display("FAIL bound_seg: got %0d expected 2", seg_cnt); end
  endtask

  task automatic test_range_err();
    do_reset();
    stream_q = '{MAGIC, 16'h018F, 16'h0003};
    model_run();
    drive_stream(1);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL range_err: got %b expected 1", err); end
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL range_nowrite: got %0d writes expected 0", obs_q.size()); end
    stream_q = '{MAGIC, 16'h0000, 16'h0001, 16'hABCD};
`ifdef ACC16_LOADER_CKSUM_EN
    stream_q.push_back(16'hABCD);
`endif
    stream_q.push_back(MAGIC); stream_q.push_back(16'h8000 | 16'd620); stream_q.push_back(16'h0004);
    stream_q.push_back(MAGIC); stream_q.push_back(16'h0000); stream_q.push_back(16'h0000);
    stream_q.push_back(MAGIC); stream_q.push_back(16'h0400); stream_q.push_back(16'h0001);
    stream_q.push_back(END_W);
    model_run();
    drive_stream(2);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL resync_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL err_no_boot: hold=%b expected 1", cpu_hold); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL err_ready: got %b expected 1", in_ready); end
    checks++; if (seg_cnt !== 8'(m_seg)) begin failures++; $display("FAIL resync_seg: got %0d expected %0d", seg_cnt, m_seg); end
  endtask

`ifdef ACC16_LOADER_CKSUM_EN
  task automatic test_cksum_mismatch();
    do_reset();
    stream_q = '{MAGIC, 16'h0000, 16'h0002, 16'h0001, 16'h0002, 16'h0004};
    model_run();
    drive_stream(1);
    checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL ck_writes: got %0d expected 2", obs_q.size()); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ck_err: got %b expected 1", err); end
    checks++; if (seg_cnt !== 8'd0) begin failures++; $display("FAIL ck_seg: got %0d expected 0", seg_cnt); end
  endtask
`endif

  task automatic test_payload_cmds();
    do_reset();
    stream_q = '{MAGIC, 16'h0010, 16'h0003, MAGIC, END_W, 16'h0007};
`ifdef ACC16_LOADER_CKSUM_EN
    stream_q.push_back(MAGIC + END_W + 16'h0007);
`endif
    model_run();
    drive_stream(0);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL cmd_as_data: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if ({err, cpu_hold} !== 2'b01) begin failures++; $display("FAIL cmd_flags: err,hold=%b expected 01", {err, cpu_hold}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stream_q = '{MAGIC, 16'h0010, 16'h0003, 16'h5A5A, 16'hC3C3};
    exp_q.push_back({1'b0, 10'd16, 16'h5A5A});
    exp_q.push_back({1'b0, 10'd17, 16'hC3C3});
    drive_stream(1);
    @(negedge clk1); rst = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL midrst_writes: got %0d writes expected 2", obs_q.size()); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b expected 0", err); end
    m_err = 0; m_seg = 0; m_hold = 1; m_done = 0;
    stream_q.push_back(16'h1234);
    make_segment(1'b0, 32, 1, 1'b0);
    model_run();
    drive_stream(0);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL midrst_idle: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (seg_cnt !== 8'd1) begin failures++; $display("FAIL midrst_seg: got %0d expected 1", seg_cnt); end
  endtask

  task automatic test_random();
    int kind, depth, base, len;
    logic sel;
    do_reset();
    for (int s = 0; s < 10; s++) begin
      kind  = int'($urandom_range(0, 9));
      sel   = 1'($urandom_range(0, 1));
      depth = sel ? DATA_DEPTH : INS_DEPTH;
      if (kind == 0) begin
        stream_q.push_back(MAGIC);
        stream_q.push_back({1'b0, 5'd3, 10'($urandom_range(0, 100))});
        stream_q.push_back(16'h0002);
      end else if (kind == 1) begin
        base = int'($urandom_range(depth - 5, depth - 1));
        stream_q.push_back(MAGIC);
        stream_q.push_back({sel, 5'd0, 10'(base)});
        stream_q.push_back(16'(depth - base + 1 + int'($urandom_range(0, 2))));
      end else begin
        len  = int'($urandom_range(1, 8));
        base = int'($urandom_range(0, depth - len));
        make_segment(sel, base, len, kind == 2);
      end
    end
    stream_q.push_back(END_W);
    model_run();
    drive_stream(2);
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL rand_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (err !== 1'(m_err)) begin failures++; $display("FAIL rand_err: got %b expected %b", err, m_err); end
    checks++; if (seg_cnt !== 8'(m_seg)) begin failures++; $display("FAIL rand_seg: got %0d expected %0d", seg_cnt, m_seg); end
    checks++; if (cpu_hold !== 1'(m_hold)) begin failures++; $display("FAIL rand_hold: got %b expected %b", cpu_hold, m_hold); end
  endtask

  task automatic test_seg_saturate();
    do_reset();
    for (int s = 0; s < 258; s++) make_segment(1'b0, int'($urandom_range(0, 400)), 1, 1'b0);
    model_run();
    drive_stream(0);
    checks++; if (seg_cnt !== 8'd255) begin failures++; $display("FAIL seg_saturate: got %0d expected 255", seg_cnt); end
    checks++; if (write_diffs() !== 0) begin failures++; $display("FAIL sat_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_boot();
    test_data_region();
    test_boundaries();
    test_range_err();
`ifdef ACC16_LOADER_CKSUM_EN
    test_cksum_mismatch();
`endif
    test_payload_cmds();
    test_reset_mid();
    test_random();
    test_seg_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
